pwm_channel_engine: RTL

//  Downstream consumer of the shared register store: reads the 2048-bit register blob written via the
//  I2C target and generates 16 PCA9685-style PWM outputs. A 12-bit period counter is advanced by a

---
 rtl/fpga9685_pkg.sv | 47 ++++
 rtl/pwm_channel.sv | 41 ++++
 rtl/pwm_channel_engine.sv | 80 ++++++++
 3 files changed

// File: rtl/fpga9685_pkg.sv
// Register map, bit positions and blob helpers shared by the PWM engine and its channels.
// The blob stores register k at bits [8k +: 8] with bit 8k holding the byte's MSB.
package fpga9685_pkg;

    localparam int unsigned BLOB_W     = 2048;
    localparam int unsigned MODE1      = 'h00;
    localparam int unsigned MODE2      = 'h01;
    localparam int unsigned LED0_ON_L  = 'h06;
    localparam int unsigned LED_STRIDE = 4;
    localparam int unsigned PRE_SCALE  = 'hFE;

    localparam int unsigned SLEEP_BIT = 4;
    localparam int unsigned INVRT_BIT = 4;
    localparam int unsigned FULL_BIT  = 4;

    localparam logic [7:0] PRESCALE_MIN = 8'd3;

    typedef struct packed {
        logic [11:0] on;
        logic [11:0] off;
        logic        full_on;
        logic        full_off;
    } chan_cfg_t;

    // Byte order inside the blob is MSB-first, so the bits are reversed on extraction.
    function automatic logic [7:0] blob_byte(input logic [BLOB_W-1:0] blob, input int unsigned addr);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = blob[8*addr + i];
        return b;
    endfunction

    function automatic logic blob_bit(input logic [BLOB_W-1:0] blob, input int unsigned addr,
                                      input int unsigned bit_idx);
        return blob[8*addr + 7 - bit_idx];
    endfunction

    // regs[0..3] = ON_L, ON_H, OFF_L, OFF_H
    function automatic chan_cfg_t decode_led(input logic [3:0][7:0] regs);
        chan_cfg_t c;
        c.on       = {regs[1][3:0], regs[0]};
        c.off      = {regs[3][3:0], regs[2]};
        c.full_on  = regs[1][FULL_BIT];
        c.full_off = regs[3][FULL_BIT];
        return c;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed ON/OFF compare set, level compare, invert and output register.
module pwm_channel
    import fpga9685_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     counter,
    input  logic            load,
    input  logic [3:0][7:0] led_regs,
    input  logic            sleep,
    input  logic            invert,
    output logic            pwm
);

    chan_cfg_t shadow;
    logic      raw;

    // full_off outranks full_on; on>off describes a pulse that straddles the wrap.
    always_comb begin
        raw = 1'b0;
        if (sleep || shadow.full_off)
            raw = 1'b0;
        else if (shadow.full_on)
            raw = 1'b1;
        else if (shadow.on < shadow.off)
            raw = (counter >= shadow.on) && (counter < shadow.off);
        else if (shadow.on > shadow.off)
            raw = (counter >= shadow.on) || (counter < shadow.off);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) shadow <= decode_led(led_regs);
            pwm <= raw ^ invert;
        end
    end

endmodule

// File: rtl/pwm_channel_engine.sv
// PCA9685-style PWM engine: oscillator divider, prescaler and 12-bit period counter driving
// NUM_CH channels whose compare values reload only at period wrap (or continuously in sleep).
module pwm_channel_engine
    import fpga9685_pkg::*;
#(
    parameter int OSC_DIV = 1,
    parameter int NUM_CH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2047:0]     register_blob_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic [11:0]       counter_o,
    output logic              cycle_start_o
);

    localparam int DIV_W = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pre_cnt;
    logic [7:0]       pre_shadow;
    logic [7:0]       eff_pre;
    logic             sleep;
    logic             invrt;
    logic             osc_tick;
    logic             cnt_tick;
    logic             wrap;
    logic             load;

    assign sleep    = blob_bit(register_blob_i, MODE1, SLEEP_BIT);
    assign invrt    = blob_bit(register_blob_i, MODE2, INVRT_BIT);
    assign eff_pre  = (pre_shadow < PRESCALE_MIN) ? PRESCALE_MIN : pre_shadow;
    assign osc_tick = !sleep && (div_cnt == DIV_W'(OSC_DIV - 1));
    assign cnt_tick = osc_tick && (pre_cnt == eff_pre);
    assign wrap     = cnt_tick && (counter_o == 12'hFFF);
    assign load     = wrap || sleep;

    // Sleep parks the whole tick chain at zero so wake-up starts a fresh period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt       <= '0;
            pre_cnt       <= '0;
            counter_o     <= '0;
            cycle_start_o <= 1'b0;
            pre_shadow    <= '0;
        end else begin
            if (sleep) begin
                div_cnt   <= '0;
                pre_cnt   <= '0;
                counter_o <= '0;
            end else begin
                div_cnt <= osc_tick ? '0 : div_cnt + DIV_W'(1);
                if (osc_tick) pre_cnt <= cnt_tick ? 8'd0 : pre_cnt + 8'd1;
                if (cnt_tick) counter_o <= counter_o + 12'd1;
            end
            cycle_start_o <= wrap;
            if (load) pre_shadow <= blob_byte(register_blob_i, PRE_SCALE);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam int unsigned BASE = LED0_ON_L + LED_STRIDE * n;
        logic [3:0][7:0] led_regs;

        assign led_regs = {blob_byte(register_blob_i, BASE + 3), blob_byte(register_blob_i, BASE + 2),
                           blob_byte(register_blob_i, BASE + 1), blob_byte(register_blob_i, BASE)};

        pwm_channel u_ch (
            .clk      (clk_i),
            .rst      (rst_i),
            .counter  (counter_o),
            .load     (load),
            .led_regs (led_regs),
            .sleep    (sleep),
            .invert   (invrt),
            .pwm      (pwm_o[n])
        );
    end

endmodule
